// File: rtl/pellet_map_if.sv
// Port bundle for pellet_map: graphics lookup, eat requests, and the game-logic status outputs.
interface pellet_map_if #(
  parameter int IDX_W = 10
);
  logic             refill;
  logic             eat_valid;
  logic [4:0]       eat_col;
  logic [4:0]       eat_row;
  logic [4:0]       rd_col;
  logic [4:0]       rd_row;
  logic             rd_pellet;
  logic             eaten;
  logic [IDX_W-1:0] remaining;
  logic             level_clear;
  logic             busy;

  modport master (
    output refill, eat_valid, eat_col, eat_row, rd_col, rd_row,
    input  rd_pellet, eaten, remaining, level_clear, busy
  );

  modport slave (
    input  refill, eat_valid, eat_col, eat_row, rd_col, rd_row,
    output rd_pellet, eaten, remaining, level_clear, busy
  );
endinterface

// File: rtl/pellet_map.sv
// Live pellet bitmap for the maze: reloads from INIT_IMAGE (bit COLS*ROWS-1 is tile 0, row-major),
// clears tiles as they are eaten, and reports eaten pulses, remaining count and level clear.
module pellet_map #(
  parameter int                   COLS       = 28,
  parameter int                   ROWS       = 31,
  parameter int                   IDX_W      = 10,
  parameter logic [COLS*ROWS-1:0] INIT_IMAGE = '1
) (
  input logic         clk,
  input logic         rst,
  pellet_map_if.slave bus
);
  localparam int               N        = COLS * ROWS;
  localparam int               AW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [4:0]       COLS_T   = 5'(COLS);
  localparam logic [4:0]       ROWS_T   = 5'(ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, CLEAR = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] remaining_reg, remaining_next;
  logic             eaten_reg, eaten_next;
  logic             rd_pellet_reg, rd_pellet_next;
  logic [N-1:0]     map_reg;

  logic             eat_in_range, rd_in_range, eat_hit, img_bit;
  logic [AW-1:0]    eat_addr, rd_addr, load_addr, img_addr;

  assign eat_in_range = (bus.eat_col < COLS_T) && (bus.eat_row < ROWS_T);
  assign rd_in_range  = (bus.rd_col < COLS_T) && (bus.rd_row < ROWS_T);
  assign eat_addr     = AW'(IDX_W'(bus.eat_row) * IDX_W'(COLS) + IDX_W'(bus.eat_col));
  assign rd_addr      = AW'(IDX_W'(bus.rd_row) * IDX_W'(COLS) + IDX_W'(bus.rd_col));
  assign load_addr    = AW'(idx_reg);
  assign img_addr     = AW'(LAST_IDX - idx_reg);
  assign img_bit      = INIT_IMAGE[img_addr];

  // Out-of-range addresses may alias; the range qualifiers mask them.
  assign eat_hit = (state_reg == RUN) && !bus.refill && bus.eat_valid
                   && eat_in_range && map_reg[eat_addr];
  // Sampled before this edge's eat write, so a same-tile read sees the pre-eat bit.
  assign rd_pellet_next = (state_reg != LOAD) && rd_in_range && map_reg[rd_addr];

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    remaining_next = remaining_reg;
    eaten_next     = 1'b0;
    if (bus.refill) begin
      state_next     = LOAD;
      idx_next       = '0;
      remaining_next = '0;
    end else begin
      case (state_reg)
        LOAD: begin
          remaining_next = remaining_reg + IDX_W'(img_bit);
          idx_next       = idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = (remaining_next == '0) ? CLEAR : RUN;
          end
        end
        RUN: begin
          if (eat_hit && (remaining_reg != '0)) begin
            remaining_next = remaining_reg - IDX_W'(1);
            eaten_next     = 1'b1;
            if (remaining_reg == IDX_W'(1)) state_next = CLEAR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= LOAD;
      idx_reg       <= '0;
      remaining_reg <= '0;
      eaten_reg     <= 1'b0;
      rd_pellet_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      remaining_reg <= remaining_next;
      eaten_reg     <= eaten_next;
      rd_pellet_reg <= rd_pellet_next;
    end
  end

  // The bitmap is not reset: every LOAD pass rewrites all of it.
  always_ff @(posedge clk) begin
    if (state_reg == LOAD) map_reg[load_addr] <= img_bit;
    else if (eat_hit)      map_reg[eat_addr]  <= 1'b0;
  end

  assign bus.rd_pellet   = rd_pellet_reg;
  assign bus.eaten       = eaten_reg;
  assign bus.remaining   = remaining_reg;
  assign bus.level_clear = (state_reg == CLEAR);
  assign bus.busy        = (state_reg == LOAD);
endmodule

// File: tb/tb_pellet_map.sv
// Self-checking bench for pellet_map on a 4x2 maze: directed scenarios plus random traffic
// compared every cycle against a tile-level reference model.
module tb_pellet_map;
  localparam int              COLS  = 4;
  localparam int              ROWS  = 2;
  localparam int              N     = COLS * ROWS;
  localparam int              IDX_W = 10;
  localparam logic [N-1:0]    IMG   = 8'b1011_0110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pellet_map_if #(.IDX_W(IDX_W)) bus ();

  pellet_map #(
    .COLS(COLS), .ROWS(ROWS), .IDX_W(IDX_W), .INIT_IMAGE(IMG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0=loading, 1=playing, 2=cleared.
  bit m_map[N];
  int m_phase, m_left, m_rem;
  bit m_eaten, m_rd;

  function automatic bit in_range(int c, int r);
    return (c < COLS) && (r < ROWS);
  endfunction

  function automatic int image_count(int k);
    int s = 0;
    for (int i = 0; i < k; i++) s += int'(IMG[N-1-i]);
    return s;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = N; m_rem = 0; m_eaten = 0; m_rd = 0;
  endtask

  task automatic model_edge();
    int ec = int'(bus.eat_col), er = int'(bus.eat_row);
    int rc = int'(bus.rd_col),  rr = int'(bus.rd_row);
    bit rd_exp = (m_phase != 0) && in_range(rc, rr) && m_map[in_range(rc, rr) ? rr*COLS+rc : 0];
    m_eaten = 0;
    if (bus.refill) begin
      m_phase = 0; m_left = N; m_rem = 0;
    end else if (m_phase == 0) begin
      m_left--;
      m_rem = image_count(N - m_left);
      if (m_left == 0) begin
        for (int i = 0; i < N; i++) m_map[i] = IMG[N-1-i];
        m_phase = (m_rem != 0) ? 1 : 2;
      end
    end else if (m_phase == 1) begin
      if (bus.eat_valid && in_range(ec, er) && m_map[er*COLS+ec]) begin
        m_map[er*COLS+ec] = 0;
        m_rem--;
        m_eaten = 1;
        if (m_rem == 0) m_phase = 2;
      end
    end
    m_rd = rd_exp;
  endtask

  task automatic compare_all();
    check_eq("busy",        32'(bus.busy),        32'(m_phase == 0));
    check_eq("level_clear", 32'(bus.level_clear), 32'(m_phase == 2));
    check_eq("remaining",   32'(bus.remaining),   32'(m_rem));
    check_eq("eaten",       32'(bus.eaten),       32'(m_eaten));
    check_eq("rd_pellet",   32'(bus.rd_pellet),   32'(m_rd));
  endtask

  task automatic step(input bit rf, input bit ev, input int ec, input int er,
                      input int rc, input int rr);
    bus.refill    = rf;
    bus.eat_valid = ev;
    bus.eat_col   = 5'(ec);
    bus.eat_row   = 5'(er);
    bus.rd_col    = 5'(rc);
    bus.rd_row    = 5'(rr);
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 7, 7);
  endtask

  int pulses;

  initial begin
    bus.refill = 0; bus.eat_valid = 0;
    bus.eat_col = '0; bus.eat_row = '0; bus.rd_col = '0; bus.rd_row = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // Initial load: busy for exactly N cycles, then 5 pellets.
    idle(N);
    check_eq("rem_after_load", 32'(bus.remaining), 32'd5);

    // Lookups: pellet, empty tile, out-of-range column.
    step(0, 0, 0, 0, 2, 0);
    check_eq("rd_col2_row0", 32'(bus.rd_pellet), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 5, 0);
    check_eq("rd_col5_oor", 32'(bus.rd_pellet), 32'd0);

    // Hold eat on (0,0) for 3 cycles while reading it.
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      pulses += int'(bus.eaten);
      if (i == 0) check_eq("rd_pre_eat", 32'(bus.rd_pellet), 32'd1);
    end
    check_eq("held_eat_pulses", 32'(pulses), 32'd1);
    check_eq("rem_after_eat", 32'(bus.remaining), 32'd4);

    // Eat the rest; last eat moves to cleared, then re-eat gives nothing.
    step(0, 1, 2, 0, 7, 7);
    step(0, 1, 3, 0, 7, 7);
    step(0, 1, 1, 1, 7, 7);
    step(0, 1, 2, 1, 7, 7);
    check_eq("level_clear_set", 32'(bus.level_clear), 32'd1);
    step(0, 1, 2, 1, 7, 7);
    step(0, 1, 0, 0, 7, 7);

    // Refill from cleared, then refill colliding with an eat.
    step(1, 0, 0, 0, 7, 7);
    check_eq("clear_dropped", 32'(bus.level_clear), 32'd0);
    idle(N);
    step(1, 1, 0, 0, 7, 7);
    check_eq("refill_beats_eat", 32'(bus.eaten), 32'd0);
    idle(N);

    // Async reset in the middle of a load.
    step(1, 0, 0, 0, 7, 7);
    idle(3);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    idle(N);
    check_eq("rem_after_reload", 32'(bus.remaining), 32'd5);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
